// File: rtl/hpu_pkg.sv
// Shared types and default sizes for the HPU palette stage.
package hpu_pkg;

  localparam int INDEX_W     = 5;
  localparam int COLOR_W     = 4;
  localparam int PAL_ENTRIES = 2 ** INDEX_W;

  typedef logic [INDEX_W-1:0] pal_idx_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_t;

endpackage

// File: rtl/hpu_palette_ram.sv
// Register-array palette: one write port, one registered read port that
// returns the pre-write contents when reading and writing the same entry.
module hpu_palette_ram
  import hpu_pkg::*;
#(
  parameter int IDX_W  = hpu_pkg::INDEX_W,
  parameter int DATA_W = 3 * hpu_pkg::COLOR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  input  logic              rd_blank,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_q, rd_d;

  // Reads use mem_q, so a same-cycle write to the read entry is not yet visible.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
    rd_d = rd_blank ? '0 : mem_q[rd_addr];
  end

  // NOTE: every entry is cleared on reset, so this array must stay in flops;
  // sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/hpu_palette.sv
// Palette lookup stage: pixel index -> 12-bit RGB with 2-cycle latency,
// timing flags delayed to match, palette loaded over a byte-wide CPU port.
module hpu_palette
  import hpu_pkg::*;
#(
  parameter int INDEX_W = hpu_pkg::INDEX_W,
  parameter int COLOR_W = hpu_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] pixel_index,
  input  logic               active_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               cpu_wr_en,
  input  logic [INDEX_W:0]   cpu_wr_addr,
  input  logic [7:0]         cpu_wr_data,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               active_out,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int RGB_W = 3 * COLOR_W;

  logic [INDEX_W-1:0] idx_q, idx_d;
  sync_t              s1_q, s1_d;
  sync_t              s2_q, s2_d;
  logic [7:0]         staging_q, staging_d;

  logic               wr_hi;
  logic [INDEX_W-1:0] wr_entry;
  logic [RGB_W-1:0]   rgb;
  logic               unused_wr_bits;

  assign wr_hi          = cpu_wr_addr[0];
  assign wr_entry       = cpu_wr_addr[INDEX_W:1];
  assign unused_wr_bits = ^cpu_wr_data[7:COLOR_W];

  always_comb begin
    idx_d     = pixel_index;
    s1_d      = '{active: active_in, hsync: hsync_in, vsync: vsync_in};
    s2_d      = s1_q;
    staging_d = staging_q;
    if (cpu_wr_en && !wr_hi) staging_d = cpu_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      staging_q <= '0;
    end else begin
      idx_q     <= idx_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      staging_q <= staging_d;
    end
  end

  // The high-byte write commits the whole entry; staging is kept for reuse.
  hpu_palette_ram #(
    .IDX_W  (INDEX_W),
    .DATA_W (RGB_W)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cpu_wr_en && wr_hi),
    .wr_addr  (wr_entry),
    .wr_data  ({cpu_wr_data[COLOR_W-1:0], staging_q}),
    .rd_addr  (idx_q),
    .rd_blank (!s1_q.active),
    .rd_data  (rgb)
  );

  assign {red, green, blue} = rgb;
  assign active_out         = s2_q.active;
  assign hsync_out          = s2_q.hsync;
  assign vsync_out          = s2_q.vsync;

endmodule

// File: tb/tb_hpu_palette.sv
// Scoreboard bench for hpu_palette: a spec-level palette model predicts each
// output word at drive time; results are popped two clock edges later.
module tb_hpu_palette;
  import hpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pixel_index;
  logic       active_in, hsync_in, vsync_in;
  logic       cpu_wr_en;
  logic [5:0] cpu_wr_addr;
  logic [7:0] cpu_wr_data;
  logic [3:0] red, green, blue;
  logic       active_out, hsync_out, vsync_out;

  always #5 clk = ~clk;

  hpu_palette dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_index (pixel_index),
    .active_in   (active_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_addr (cpu_wr_addr),
    .cpu_wr_data (cpu_wr_data),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .active_out  (active_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out)
  );

  typedef struct packed {
    rgb_t  rgb;
    sync_t flags;
  } out_t;

  out_t        exp_q[$];
  logic [11:0] pal_m [PAL_ENTRIES];
  logic [7:0]  stg_m;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic out_t observed();
    out_t o;
    o.rgb   = '{r: red, g: green, b: blue};
    o.flags = '{active: active_out, hsync: hsync_out, vsync: vsync_out};
    return o;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < PAL_ENTRIES; i++) pal_m[i] = 12'h000;
    stg_m = 8'h00;
  endfunction

  // One clock: drive inputs, predict, advance, compare the oldest prediction.
  task automatic drive(input string tag, input logic [4:0] idx, input logic act,
                       input logic hs, input logic vs, input logic we,
                       input logic [5:0] addr, input logic [7:0] data);
    out_t e;
    out_t o;
    pixel_index = idx;
    active_in   = act;
    hsync_in    = hs;
    vsync_in    = vs;
    cpu_wr_en   = we;
    cpu_wr_addr = addr;
    cpu_wr_data = data;
    if (we) begin
      if (addr[0]) pal_m[addr[5:1]] = {data[3:0], stg_m};
      else         stg_m = data;
    end
    e.rgb   = act ? rgb_t'(pal_m[idx]) : rgb_t'(12'h000);
    e.flags = '{active: act, hsync: hs, vsync: vs};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = observed();
    e = exp_q.pop_front();
    check(tag, {17'b0, o}, {17'b0, e});
  endtask

  task automatic idle(input string tag);
    drive(tag, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic cpu_write(input string tag, input logic [4:0] entry, input logic hi,
                           input logic [7:0] data);
    drive(tag, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, {entry, hi}, data);
  endtask

  task automatic apply_reset(input string tag);
    reset       = 1'b1;
    active_in   = 1'b1;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    pixel_index = 5'd5;
    cpu_wr_en   = 1'b1;
    cpu_wr_addr = {5'd5, 1'b1};
    cpu_wr_data = 8'hFF;
    @(posedge clk);
    #1;
    check({tag, "_rgb"}, {20'b0, red, green, blue}, 32'h0);
    check({tag, "_flags"}, {29'b0, active_out, hsync_out, vsync_out}, 32'h0);
    reset     = 1'b0;
    cpu_wr_en = 1'b0;
    model_clear();
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  initial begin
    reset       = 1'b1;
    pixel_index = '0;
    active_in   = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    cpu_wr_en   = 1'b0;
    cpu_wr_addr = '0;
    cpu_wr_data = '0;
    model_clear();
    @(posedge clk);
    apply_reset("por");

    // Post-reset palette is black; active flag delayed exactly two cycles.
    drive("t1_idx7", 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    idle("t1_drain0");
    idle("t1_drain1");

    // Two-byte commit to entry 3, then read it.
    cpu_write("t2_lo", 5'd3, 1'b0, 8'hA5);
    cpu_write("t2_hi", 5'd3, 1'b1, 8'h0C);
    drive("t2_rd3", 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    idle("t2_drain0");
    idle("t2_drain1");
    check("t2_model_e3", {20'b0, pal_m[3]}, 32'hCA5);

    // Blanking: active low forces black; syncs pass through.
    for (int i = 0; i < 6; i++)
      drive("t3_blank", 5'd9, 1'b0, 1'(i % 2), 1'(i / 3), (i == 0), {5'd9, 1'b1}, 8'hFF);
    idle("t3_drain0");
    idle("t3_drain1");

    // Read-during-write on entry 4 while streaming index 4.
    cpu_write("t4_lo", 5'd4, 1'b0, 8'h23);
    cpu_write("t4_hi", 5'd4, 1'b1, 8'h01);
    drive("t4_s0", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    drive("t4_s1", 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, {5'd4, 1'b0}, 8'h56);
    drive("t4_s2", 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, {5'd4, 1'b1}, 8'h04);
    drive("t4_s3", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    drive("t4_s4", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    idle("t4_drain0");
    idle("t4_drain1");

    // Shared staging byte reused by consecutive high-byte writes.
    cpu_write("t5_lo", 5'd0, 1'b0, 8'h3C);
    cpu_write("t5_hi1", 5'd1, 1'b1, 8'h01);
    cpu_write("t5_hi2", 5'd2, 1'b1, 8'hF2);
    drive("t5_rd1", 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    drive("t5_rd2", 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    idle("t5_drain0");
    idle("t5_drain1");
    check("t5_model_e1", {20'b0, pal_m[1]}, 32'h13C);
    check("t5_model_e2", {20'b0, pal_m[2]}, 32'h23C);

    // Reset mid-stream clears palette, staging and in-flight pixels.
    cpu_write("t6_lo", 5'd5, 1'b0, 8'hFF);
    cpu_write("t6_hi", 5'd5, 1'b1, 8'h0F);
    drive("t6_rd5", 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    drive("t6_pend_lo", 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, {5'd6, 1'b0}, 8'h99);
    apply_reset("t6_reset");
    drive("t6_rd5_after", 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    cpu_write("t6_hi_only", 5'd6, 1'b1, 8'h07);
    drive("t6_rd6", 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    idle("t6_drain0");
    idle("t6_drain1");
    check("t6_model_e6", {20'b0, pal_m[6]}, 32'h700);

    // Random mix of pixels, flags and CPU writes, including the top entry.
    for (int i = 0; i < 300; i++) begin
      logic we;
      we = ($urandom_range(0, 3) == 0);
      drive("rand", 5'($urandom_range(0, 31)), 1'($urandom_range(0, 4) != 0),
            1'($urandom), 1'($urandom), we, 6'($urandom), 8'($urandom));
    end
    drive("top_lo", 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, {5'd31, 1'b0}, 8'hE7);
    drive("top_hi", 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, {5'd31, 1'b1}, 8'hAB);
    drive("top_rd", 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 8'h00);
    idle("end_drain0");
    idle("end_drain1");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hpu_palette.md
Name: hpu_palette

Overview:
- Downstream stage of the HPU tile core.
- Consumes the 5-bit tile pixel index each cycle and converts it to 12-bit RGB (4:4:4) through a 32-entry palette of registers.
- Delays the display timing flags (active, hsync, vsync) so they stay aligned with the colour output.
- The palette is written by a byte-wide CPU port; two byte writes assemble each 12-bit entry.

Parameters:
- INDEX_W, 5, width of pixel index; palette depth is 2**INDEX_W.
- COLOR_W, 4, bits per colour channel.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_index  in  INDEX_W  palette index from tile core (tile_pixel_out)
- active_in  in  1  pixel is inside the visible area, same cycle as pixel_index
- hsync_in  in  1  horizontal sync, same cycle as pixel_index
- vsync_in  in  1  vertical sync, same cycle as pixel_index
- cpu_wr_en  in  1  byte write strobe, one byte per cycle
- cpu_wr_addr  in  INDEX_W+1  byte address: {entry, hi}; hi=0 is the low byte, hi=1 is the high byte
- cpu_wr_data  in  8  write data
- red  out  COLOR_W  red channel
- green  out  COLOR_W  green channel
- blue  out  COLOR_W  blue channel
- active_out  out  1  active_in delayed 2 cycles
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles

Behaviour:
- Reset: on a clock edge with reset=1:
  - all palette entries = 12'h000; staging byte = 8'h00;
  - both pipeline stages clear, so red/green/blue/active_out/hsync_out/vsync_out = 0 on the following cycle.
- Reset mid-operation:
  - an in-flight pixel is discarded;
  - a pending low-byte stage is lost (an entry commits only on the high-byte write).
- Pipeline, latency exactly 2 cycles:
  - S1 (edge N): register pixel_index, active, hsync, vsync.
  - S2 (edge N+1): read palette[S1 index] into the colour output registers; advance the flags.
  - An input applied before edge N appears on the outputs after edge N+1.
- Blanking: when the S1 active flag is 0, S2 loads red/green/blue = 0 regardless of index. Syncs pass through unaltered.
- Entry format: bits [11:8]=R, [7:4]=G, [3:0]=B.
- Low-byte write (wr_en, hi=0):
  - staging <= cpu_wr_data, giving {G,B};
  - palette is unchanged.
- High-byte write (wr_en, hi=1):
  - palette[entry] <= {cpu_wr_data[3:0], staging};
  - cpu_wr_data[7:4] is ignored; staging is retained.
- Staging state:
  - A high-byte write with no preceding low-byte write uses the current staging value (0 after reset).
  - Repeated high-byte writes to different entries reuse the same staging value.
  - The staging byte is shared by all entries and is not tied to the low-byte entry address.
- Read-during-write:
  - If S2 reads entry E in the same cycle a high-byte commit writes E, the output gets the old value.
  - The new value is visible to S2 reads from the next cycle on.
- Writes are accepted at any time, including active display. There is no back-pressure and no ready signal.
- All indices are full-range; there is no out-of-range case.

Decomposition:
- Package hpu_pkg holds:
  - INDEX_W and COLOR_W defaults;
  - typedef rgb_t (packed struct r,g,b of COLOR_W);
  - typedef pal_idx_t (logic [INDEX_W-1:0]);
  - localparam PAL_ENTRIES.
- Sub-module hpu_palette_ram: 2**INDEX_W x 3*COLOR_W register array with one write port and one registered read port, read-before-write, synchronous reset clear.
- The top level holds the staging byte, the write decode and the flag pipeline.

Test Plan:
- Reset, then active_in=1, index=7 -> after 2 cycles RGB=000; active_out=1 exactly 2 cycles after active_in.
- Write low byte 0xA5 to addr {3,0}, then 0x0C to {3,1}; drive index=3 with active=1 -> red=C, green=A, blue=5 at latency 2.
- Write 0xFF to {9,1} with active=0 throughout -> outputs 0; hsync_out/vsync_out mirror the inputs delayed 2 cycles.
- Entry 4 = 0x123, then stream index=4 continuously while committing 0x0456 to entry 4 in cycle T -> output from the read at T is 0x123; the read at T+1 gives 0x456.
- Write low byte 0x3C, then high bytes 0x01 to entry 1 and 0x02 to entry 2 -> entry1=0x13C, entry2=0x23C.
- Set entry 5 = 0xFFF, reset for 1 cycle, read index 5 -> 0x000; staging cleared (a high-byte write of 0x07 gives 0x700).
